window_gen_v_3_uint10: RTL and testbench

Vertical 3×1 window generator for 10-bit unsigned raster pixels. It buffers the two previous image rows and emits, per pixel, the column [row−1, row, row+1] centred on that pixel. Missing rows at the top and bottom image borders are zero-padded. It is the producer that feeds the vertical 3-tap box filter (`custom_box_v_3_uint10_to_uint12`) with its `window_i` / `col_i` / `row_i` / `valid_i` stream. It sits between the pixel source and that filter.

---
 rtl/window_gen_v_3_uint10_if.sv | 23 ++
 rtl/window_gen_v_3_uint10.sv | 108 ++++++++++
 tb/tb_window_gen_v_3_uint10.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/window_gen_v_3_uint10_if.sv
// Pixel-in / window-out stream bundle for the vertical 3x1 window generator.
// The slave side is the generator; the master side is the pixel source and window sink.
interface window_gen_v_3_uint10_if;
  logic [9:0]            data_i;
  logic [15:0]           col_i;
  logic [15:0]           row_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [2:0][0:0][9:0]  window_o;
  logic [15:0]           col_o;
  logic [15:0]           row_o;
  logic                  valid_o;

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/window_gen_v_3_uint10.sv
// Vertical 3x1 window generator for uint10 raster pixels. It keeps two line buffers and
// zero-pads the top and bottom borders; the last row is emitted by a FLUSH pass.
module window_gen_v_3_uint10 #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  window_gen_v_3_uint10_if.slave         bus
);

  localparam int unsigned FcW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [0:0] {StStream, StFlush} state_e;

  state_e               state_q, state_d;
  logic [FcW-1:0]       fc_q, fc_d;
  logic [FcW-1:0]       addr;
  logic [9:0]           lb1_q [IMG_W];
  logic [9:0]           lb2_q [IMG_W];
  logic [9:0]           rd1, rd2;
  logic                 accept;

  logic                 valid_q, valid_d;
  logic [2:0][0:0][9:0] window_q, window_d;
  logic [15:0]          col_q, col_d;
  logic [15:0]          row_q, row_d;

  assign bus.ready_o  = (state_q == StStream);
  assign accept       = bus.valid_i && bus.ready_o;
  assign addr         = (state_q == StFlush) ? fc_q : bus.col_i[FcW-1:0];
  assign rd1          = lb1_q[addr];
  assign rd2          = lb2_q[addr];

  assign bus.valid_o  = valid_q;
  assign bus.window_o = window_q;
  assign bus.col_o    = col_q;
  assign bus.row_o    = row_q;

  // Old lb1 shifts into lb2 in the same edge, so reads always see pre-write contents.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_q[addr] <= bus.data_i;
      lb2_q[addr] <= rd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q;
    valid_d  = 1'b0;
    window_d = window_q;
    col_d    = col_q;
    row_d    = row_q;
    unique case (state_q)
      StStream: begin
        if (accept) begin
          if (bus.row_i != 16'd0) begin
            valid_d        = 1'b1;
            window_d[0][0] = (bus.row_i == 16'd1) ? 10'd0 : rd2;
            window_d[1][0] = rd1;
            window_d[2][0] = bus.data_i;
            col_d          = bus.col_i;
            row_d          = bus.row_i - 16'd1;
          end
          if (bus.col_i == 16'(IMG_W - 1) && bus.row_i == 16'(IMG_H - 1)) begin
            state_d = StFlush;
            fc_d    = '0;
          end
        end
      end
      StFlush: begin
        valid_d        = 1'b1;
        window_d[0][0] = rd2;
        window_d[1][0] = rd1;
        window_d[2][0] = 10'd0;
        col_d          = 16'(fc_q);
        row_d          = 16'(IMG_H - 1);
        if (fc_q == FcW'(IMG_W - 1)) begin
          state_d = StStream;
          fc_d    = '0;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
      default: state_d = StStream;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StStream;
      fc_q     <= '0;
      valid_q  <= 1'b0;
      window_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      valid_q  <= valid_d;
      window_q <= window_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

endmodule

// File: tb/tb_window_gen_v_3_uint10.sv
// Directed bench for the vertical 3x1 window generator on a 4x3 image: borders, flush,
// held input across flush, max-value pixels and asynchronous reset mid-frame.
module tb_window_gen_v_3_uint10;
  localparam int unsigned W = 4;
  localparam int unsigned H = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  window_gen_v_3_uint10_if bus ();

  window_gen_v_3_uint10 #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int c, input int r, input int d);
    bus.valid_i = 1'b1;
    bus.col_i   = 16'(c);
    bus.row_i   = 16'(r);
    bus.data_i  = 10'(d);
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c,
                         input int col, input int row);
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    chk({tag, ".above"}, 32'(bus.window_o[0][0]), 32'(a));
    chk({tag, ".centre"}, 32'(bus.window_o[1][0]), 32'(b));
    chk({tag, ".below"}, 32'(bus.window_o[2][0]), 32'(c));
    chk({tag, ".col"}, 32'(bus.col_o), 32'(col));
    chk({tag, ".row"}, 32'(bus.row_o), 32'(row));
  endtask

  initial begin
    logic [11:0] sum;
    rst_ni      = 1'b0;
    bus.valid_i = 1'b0;
    bus.col_i   = '0;
    bus.row_i   = '0;
    bus.data_i  = '0;
    #2;
    chk("rst.valid", 32'(bus.valid_o), 32'd0);
    chk("rst.window", 32'(bus.window_o), 32'd0);
    chk("rst.col", 32'(bus.col_o), 32'd0);
    chk("rst.row", 32'(bus.row_o), 32'd0);
    #6 rst_ni = 1'b1;
    step();
    chk("rst.ready", 32'(bus.ready_o), 32'd1);

    // Frame 1: pixel = 10*r + c.
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        chk("f1.ready_in", 32'(bus.ready_o), 32'd1);
        drive(c, r, 10 * r + c);
        step();
        if (r == 0) chk("f1.row0_quiet", 32'(bus.valid_o), 32'd0);
        else chk_win("f1.win", (r == 1) ? 0 : 10 * (r - 2) + c, 10 * (r - 1) + c,
                     10 * r + c, c, r - 1);
      end
    end
    chk_win("f1.interior_c3", 3, 13, 23, 3, 1);
    chk("f1.ready_low_t1", 32'(bus.ready_o), 32'd0);

    // Next frame's (0,0) is held across the whole flush.
    drive(0, 0, 1023);
    for (int f = 0; f < int'(W); f++) begin
      step();
      chk_win("f1.flush", 10 + f, 20 + f, 0, f, 2);
      chk("f1.flush_ready", 32'(bus.ready_o), (f == int'(W) - 1) ? 32'd1 : 32'd0);
    end
    step();
    chk("f2.held_row0_quiet", 32'(bus.valid_o), 32'd0);

    // Frame 2: all pixels at max value; (0,0) already accepted above.
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        if (r == 0 && c == 0) continue;
        drive(c, r, 1023);
        step();
        if (r == 0) chk("f2.row0_quiet", 32'(bus.valid_o), 32'd0);
        else begin
          chk_win("f2.win", (r == 1) ? 0 : 1023, 1023, 1023, c, r - 1);
          if (r == 2) begin
            sum = 12'(bus.window_o[0][0]) + 12'(bus.window_o[1][0]) + 12'(bus.window_o[2][0]);
            chk("f2.sum", 32'(sum), 32'd3069);
          end
        end
      end
    end
    bus.valid_i = 1'b0;
    for (int f = 0; f < int'(W); f++) begin
      step();
      chk_win("f2.flush", 1023, 1023, 0, f, 2);
    end
    step();
    chk("f2.idle_valid", 32'(bus.valid_o), 32'd0);
    chk("f2.idle_ready", 32'(bus.ready_o), 32'd1);

    // Frame 3 interrupted by reset during row 1.
    for (int c = 0; c < int'(W); c++) begin
      drive(c, 0, c);
      step();
    end
    for (int c = 0; c < 2; c++) begin
      drive(c, 1, 10 + c);
      step();
      chk_win("f3.win", 0, c, 10 + c, c, 0);
    end
    bus.valid_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    chk("mid_rst.valid", 32'(bus.valid_o), 32'd0);
    chk("mid_rst.window", 32'(bus.window_o), 32'd0);
    #2 rst_ni = 1'b1;
    chk("mid_rst.ready", 32'(bus.ready_o), 32'd1);
    step();

    // Frame 4 from row 0 reproduces the top-border window.
    for (int c = 0; c < int'(W); c++) begin
      drive(c, 0, c);
      step();
      chk("f4.row0_quiet", 32'(bus.valid_o), 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      drive(c, 1, 10 + c);
      step();
    end
    chk_win("f4.top_c2", 0, 2, 12, 2, 0);
    bus.valid_i = 1'b0;
    step();
    chk("f4.idle_valid", 32'(bus.valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
